// File: rtl/ah_snoop_fifo_param_pkg.sv
// Shared helpers for the snoopable FIFO: derived widths, wrapping index increment, popcount.
`default_nettype none

package snoop_fifo_pkg;

    // Upper bound on the hit vector that popcount can sum.
    localparam int unsigned POP_MAX = 1024;

    function automatic int unsigned idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned idx_next(input int unsigned idx, input int unsigned depth);
        return (idx == depth - 1) ? 0 : idx + 1;
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ah_snoop_fifo_param_cam.sv
// snoop_cam_match: combinational per-entry key compare qualified by entry valid.
// With SNOOP_MASK_EN defined the compare ignores key bits where smask_i is 0.
`default_nettype none

module snoop_cam_match #(
    parameter int DEPTH   = 78,
    parameter int SNOOP_W = 16,
    parameter int CNT_W   = 7
) (
    input  logic [SNOOP_W-1:0] keys_i [DEPTH],
    input  logic [DEPTH-1:0]   valid_i,
    input  logic [SNOOP_W-1:0] sdata_i,
`ifdef SNOOP_MASK_EN
    input  logic [SNOOP_W-1:0] smask_i,
`endif
    output logic               match_o,
    output logic [CNT_W-1:0]   count_o
);
    import snoop_fifo_pkg::*;

    logic [DEPTH-1:0] w_hit;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
`ifdef SNOOP_MASK_EN
        assign w_hit[i] = valid_i[i] & (((keys_i[i] ^ sdata_i) & smask_i) == '0);
`else
        assign w_hit[i] = valid_i[i] & (keys_i[i] == sdata_i);
`endif
    end

    assign match_o = |w_hit;
    assign count_o = CNT_W'(popcount(POP_MAX'(w_hit)));

endmodule

`default_nettype wire

// File: rtl/ah_snoop_fifo_param.sv
// ah_snoop_fifo_param: show-ahead valid/ready FIFO of any depth >= 2 with a registered
// content-snoop port. Define SNOOP_MASK_EN to add the smask input for masked compares.
`default_nettype none

module ah_snoop_fifo_param #(
    parameter int DATA_W    = 40,
    parameter int DEPTH     = 78,
    parameter int SNOOP_W   = 16,
    parameter int SNOOP_LSB = 0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [DATA_W-1:0]            rdata,
    output logic                         rvalid,
    input  logic                         rready,
    input  logic [SNOOP_W-1:0]           sdata,
    input  logic                         svalid,
`ifdef SNOOP_MASK_EN
    input  logic [SNOOP_W-1:0]           smask,
`endif
    output logic                         smatch,
    output logic [$clog2(DEPTH+1)-1:0]   scount,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    import snoop_fifo_pkg::*;

    localparam int IDX_W = idx_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               smatch_q;
    logic [CNT_W-1:0]   scount_q;

    logic               push, pop;
    logic               cam_match;
    logic [CNT_W-1:0]   cam_count;
    logic [SNOOP_W-1:0] keys [DEPTH];

    assign wready    = (count_q != CNT_W'(DEPTH));
    assign rvalid    = (count_q != '0);
    assign rdata     = mem_q[rd_idx_q];
    assign occupancy = count_q;
    assign smatch    = smatch_q;
    assign scount    = scount_q;

    assign push = wvalid & wready;
    assign pop  = rvalid & rready;

    assign wr_idx_d = IDX_W'(idx_next(32'(wr_idx_q), DEPTH));
    assign rd_idx_d = IDX_W'(idx_next(32'(rd_idx_q), DEPTH));

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_key
        assign keys[i] = mem_q[i][SNOOP_LSB +: SNOOP_W];
    end

    // The CAM sees registered state only, so a same-cycle push/pop is not reflected.
    snoop_cam_match #(
        .DEPTH   (DEPTH),
        .SNOOP_W (SNOOP_W),
        .CNT_W   (CNT_W)
    ) u_cam (
        .keys_i  (keys),
        .valid_i (valid_q),
        .sdata_i (sdata),
`ifdef SNOOP_MASK_EN
        .smask_i (smask),
`endif
        .match_o (cam_match),
        .count_o (cam_count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q  <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
            smatch_q <= 1'b0;
            scount_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_idx_q]   <= wdata;
                valid_q[wr_idx_q] <= 1'b1;
                wr_idx_q          <= wr_idx_d;
            end
            if (pop) begin
                valid_q[rd_idx_q] <= 1'b0;
                rd_idx_q          <= rd_idx_d;
            end
            count_q  <= count_d;
            smatch_q <= svalid & cam_match;
            scount_q <= svalid ? cam_count : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ah_snoop_fifo_param.sv
// Directed self-checking bench for ah_snoop_fifo_param at default parameters.
`default_nettype none

module tb_ah_snoop_fifo_param;
    localparam int DATA_W  = 40;
    localparam int DEPTH   = 78;
    localparam int SNOOP_W = 16;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic               clk;
    logic               rstn;
    logic [DATA_W-1:0]  wdata;
    logic               wvalid;
    logic               wready;
    logic [DATA_W-1:0]  rdata;
    logic               rvalid;
    logic               rready;
    logic [SNOOP_W-1:0] sdata;
    logic               svalid;
`ifdef SNOOP_MASK_EN
    logic [SNOOP_W-1:0] smask;
`endif
    logic               smatch;
    logic [CNT_W-1:0]   scount;
    logic [CNT_W-1:0]   occupancy;

    int n_vec  = 0;
    int n_miss = 0;

    ah_snoop_fifo_param #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .SNOOP_W   (SNOOP_W),
        .SNOOP_LSB (0)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wdata     (wdata),
        .wvalid    (wvalid),
        .wready    (wready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .sdata     (sdata),
        .svalid    (svalid),
`ifdef SNOOP_MASK_EN
        .smask     (smask),
`endif
        .smatch    (smatch),
        .scount    (scount),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        wdata  = d;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
    endtask

    task automatic pop();
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        rstn   = 1'b0;
        wdata  = '0;
        wvalid = 1'b0;
        rready = 1'b0;
        sdata  = '0;
        svalid = 1'b0;
`ifdef SNOOP_MASK_EN
        smask  = '1;
`endif
        do_reset();

        chk("rst_wready", 64'(wready), 64'd1);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_occ",    64'(occupancy), 64'd0);
        chk("rst_smatch", 64'(smatch), 64'd0);
        chk("rst_scount", 64'(scount), 64'd0);
        chk("rst_rdata",  64'(rdata), 64'd0);

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 5; i++) push(40'(100 + i));
        chk("mid_occ5", 64'(occupancy), 64'd5);
        sdata  = 16'd100;
        svalid = 1'b1;
        #2;
        rstn   = 1'b0;
        #1;
        chk("mid_rst_occ",    64'(occupancy), 64'd0);
        chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
        chk("mid_rst_wready", 64'(wready), 64'd1);
        svalid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_smatch", 64'(smatch), 64'd0);
        chk("post_rst_occ",    64'(occupancy), 64'd0);

        // Empty push: no bypass, visible next cycle
        wdata  = 40'hA1;
        wvalid = 1'b1;
        #1;
        chk("empty_no_bypass", 64'(rvalid), 64'd0);
        tick();
        wvalid = 1'b0;
        chk("empty_push_rvalid", 64'(rvalid), 64'd1);
        chk("empty_push_rdata",  64'(rdata), 64'hA1);

        // Simultaneous push/pop at count=1
        wdata  = 40'hB2;
        wvalid = 1'b1;
        rready = 1'b1;
        tick();
        wvalid = 1'b0;
        rready = 1'b0;
        chk("pp1_occ",   64'(occupancy), 64'd1);
        chk("pp1_rdata", 64'(rdata), 64'hB2);
        pop();
        chk("pp1_drain", 64'(occupancy), 64'd0);

        // Fill to DEPTH, overflow attempt, full push+pop
        for (int i = 0; i < DEPTH; i++) push(40'(i));
        chk("full_occ",    64'(occupancy), 64'd78);
        chk("full_wready", 64'(wready), 64'd0);
        push(40'd999);
        chk("ovf_occ", 64'(occupancy), 64'd78);
        wdata  = 40'd555;
        wvalid = 1'b1;
        rready = 1'b1;
        #1;
        chk("full_head", 64'(rdata), 64'd0);
        tick();
        wvalid = 1'b0;
        rready = 1'b0;
        chk("fullpp_occ",    64'(occupancy), 64'd77);
        chk("fullpp_wready", 64'(wready), 64'd1);
        for (int i = 1; i < DEPTH; i++) begin
            chk("drain1", 64'(rdata), 64'(i));
            pop();
        end
        chk("drain1_empty", 64'(rvalid), 64'd0);

        // Offset the indices so the second fill wraps 77->0 mid-stream
        for (int i = 0; i < 40; i++) push(40'(i));
        for (int i = 0; i < 40; i++) pop();
        for (int i = 0; i < DEPTH; i++) push(40'(200 + i));
        chk("fill2_occ", 64'(occupancy), 64'd78);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain2", 64'(rdata), 64'(200 + i));
            pop();
        end
        chk("drain2_occ", 64'(occupancy), 64'd0);

        // Snoop hits
        push(40'hAA_0000_1234);
        push(40'h00_0000_5555);
        push(40'h00_0000_1234);
        sdata  = 16'h1234;
        svalid = 1'b1;
        tick();
        svalid = 1'b0;
        chk("snp_hit_match", 64'(smatch), 64'd1);
        chk("snp_hit_count", 64'(scount), 64'd2);
        sdata  = 16'hBEEF;
        svalid = 1'b1;
        tick();
        svalid = 1'b0;
        chk("snp_miss_match", 64'(smatch), 64'd0);
        chk("snp_miss_count", 64'(scount), 64'd0);
        sdata = 16'h1234;
        tick();
        chk("snp_idle_match", 64'(smatch), 64'd0);
        chk("snp_idle_count", 64'(scount), 64'd0);

        // Snoop against pre-update state while head pops and a match pushes
        wdata  = 40'h00_0000_1234;
        wvalid = 1'b1;
        rready = 1'b1;
        sdata  = 16'h1234;
        svalid = 1'b1;
        tick();
        wvalid = 1'b0;
        rready = 1'b0;
        chk("snp_ord_count", 64'(scount), 64'd2);
        chk("snp_ord_match", 64'(smatch), 64'd1);
        chk("snp_ord_head",  64'(rdata), 64'h5555);
        tick();
        svalid = 1'b0;
        chk("snp_ord2_count", 64'(scount), 64'd2);
        chk("snp_ord2_occ",   64'(occupancy), 64'd3);

`ifdef SNOOP_MASK_EN
        do_reset();
        push(40'h12F0);
        push(40'h1200);
        sdata  = 16'h1200;
        smask  = 16'hFF00;
        svalid = 1'b1;
        tick();
        chk("mask_ff00", 64'(scount), 64'd2);
        smask = 16'hFFFF;
        tick();
        chk("mask_ffff", 64'(scount), 64'd1);
        smask = 16'h0000;
        tick();
        svalid = 1'b0;
        chk("mask_zero", 64'(scount), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
